// File: rtl/temp_display_driver.sv
// temp_display_driver: captures a binary temperature and its unit on ld,
// converts the value to BCD with a serial double-dabble engine, and scans
// four active-low seven-segment digits (digit 3 = unit letter, 2..0 = value).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module temp_display_driver #(
  parameter int DATA_W      = 10,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        sel,
  input  logic              ld,
  output logic              busy,
  output logic              done,
  output logic [3:0]        an,
  output logic [6:0]        seg
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] bin_reg;
  logic [11:0]       bcd_reg;
  logic [11:0]       bcd_adj;
  logic [CNT_W-1:0]  iter_reg;
  logic [1:0]        unit_reg;
  logic              ovf_reg;
  logic              done_reg;

  logic [REF_W-1:0]  ref_reg, ref_next;
  logic [1:0]        idx_reg, idx_next;
  logic              valid_reg, valid_next;
  logic [3:0]        hund_reg, hund_next, tens_reg, tens_next, ones_reg, ones_next;
  logic [1:0]        dunit_reg, dunit_next;
  logic              dovf_reg, dovf_next;
  logic [3:0]        an_reg, an_next;
  logic [6:0]        seg_reg, seg_next;
  logic [3:0]        dig;
  logic              blank, blank_h, blank_t;
  logic              unused_bits;

  // Decimal digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Unit letter: F, C, or H standing in for Kelvin.
  function automatic logic [6:0] unit_seg(input logic [1:0] u);
    case (u)
      2'b00:   unit_seg = 7'b0001110;
      2'b01:   unit_seg = 7'b1000110;
      default: unit_seg = 7'b0001001;
    endcase
  endfunction

  // Add-3 correction for every BCD nibble that will reach 10 after the shift.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // The top carry only matters for values > 999, which show dashes anyway.
  assign unused_bits = bcd_adj[11];

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM next-state and busy decode.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE:   if (ld) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (iter_reg == CNT_W'(DATA_W - 1)) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: capture on ld, then one adjust-and-shift per cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      iter_reg <= '0;
      unit_reg <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == COMMIT);
      case (state_reg)
        IDLE: if (ld) begin
          bin_reg  <= value;
          unit_reg <= sel;
          ovf_reg  <= (32'(value) > 32'd999);
          bcd_reg  <= '0;
          iter_reg <= '0;
        end
        SHIFT: begin
          {bcd_reg, bin_reg} <= {bcd_adj[10:0], bin_reg, 1'b0};
          iter_reg           <= iter_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Refresh scan, display latch on commit, and next an/seg so both stay aligned.
  always_comb begin
    ref_next = ref_reg + REF_W'(1);
    idx_next = idx_reg;
    if (ref_reg == REF_W'(REFRESH_DIV - 1)) begin
      ref_next = '0;
      idx_next = idx_reg + 2'd1;
    end
    hund_next  = hund_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    dunit_next = dunit_reg;
    dovf_next  = dovf_reg;
    valid_next = valid_reg;
    if (state_reg == COMMIT) begin
      hund_next  = bcd_reg[11:8];
      tens_next  = bcd_reg[7:4];
      ones_next  = bcd_reg[3:0];
      dunit_next = unit_reg;
      dovf_next  = ovf_reg;
      valid_next = 1'b1;
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank_h = (hund_next == 4'd0);
    blank_t = (hund_next == 4'd0) && (tens_next == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    dig   = ones_next;
    blank = 1'b0;
    case (idx_next)
      2'd1: begin dig = tens_next; blank = blank_t; end
      2'd2: begin dig = hund_next; blank = blank_h; end
      default: dig = ones_next;
    endcase
    seg_next = 7'b1111111;
    if (valid_next) begin
      if (idx_next == 2'd3)  seg_next = unit_seg(dunit_next);
      else if (dovf_next)    seg_next = 7'b0111111;
      else if (!blank)       seg_next = dec7(dig);
    end
    an_next = valid_next ? ~(4'b0001 << idx_next) : 4'b1111;
  end

  // Display and refresh registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ref_reg   <= '0;
      idx_reg   <= 2'd0;
      valid_reg <= 1'b0;
      hund_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      dunit_reg <= 2'd0;
      dovf_reg  <= 1'b0;
      an_reg    <= 4'b1111;
      seg_reg   <= 7'b1111111;
    end else begin
      ref_reg   <= ref_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      hund_reg  <= hund_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      dunit_reg <= dunit_next;
      dovf_reg  <= dovf_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
    end
  end

  assign done = done_reg;
  assign an   = an_reg;
  assign seg  = seg_reg;

endmodule

// File: tb/tb_temp_display_driver.sv
// Testbench for temp_display_driver with REFRESH_DIV=4: table of conversions
// checked for latency, busy length, single done pulse and full digit scan,
// plus hand sequences for reset, display hold and mid-conversion abort.
module tb_temp_display_driver;

  localparam int DW = 10;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                         D9 = 7'b0010000, DASH = 7'b0111111, BLK = 7'b1111111,
                         UF = 7'b0001110, UC = 7'b1000110, UK = 7'b0001001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLK;
`else
  localparam logic [6:0] LZ = D0;
`endif

  typedef struct {
    logic [DW-1:0]   val;
    logic [1:0]      sel;
    int              extra;   // cycle of a second ld while busy, 0 = none
    logic [3:0][6:0] segs;    // [0]=ones [1]=tens [2]=hundreds [3]=unit
  } vec_t;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] value = '0;
  logic [1:0]    sel = 2'b00;
  logic          ld = 1'b0;
  logic          busy, done;
  logic [3:0]    an;
  logic [6:0]    seg;

  int   total = 0;
  int   bad = 0;
  int   mcnt;
  logic mvalid = 1'b0;
  vec_t cur;
  vec_t vecs[6];

  temp_display_driver #(.DATA_W(DW), .REFRESH_DIV(4)) dut (
    .clk(clk), .clr(clr), .value(value), .sel(sel), .ld(ld),
    .busy(busy), .done(done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Free-running scan model: edges since the last reset release.
  always @(posedge clk or negedge clr) begin
    if (!clr) mcnt <= 0;
    else      mcnt <= mcnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [DW-1:0] v, input logic [1:0] s, input int ex,
                              input logic [6:0] o, input logic [6:0] t,
                              input logic [6:0] h, input logic [6:0] u);
    vec_t r;
    r.val = v; r.sel = s; r.extra = ex;
    r.segs = {u, h, t, o};
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_disp(input string nm);
    logic [3:0] ea;
    logic [6:0] es;
    int ix;
    ix = (mcnt / 4) % 4;
    if (!mvalid) begin
      ea = 4'b1111;
      es = 7'b1111111;
    end else begin
      ea = ~(4'b0001 << ix);
      es = cur.segs[ix];
    end
    check(nm, {21'd0, an, seg}, {21'd0, ea, es});
  endtask

  task automatic run_conv(input vec_t v);
    int nbusy, donej, extra_done;
    @(negedge clk);
    value = v.val; sel = v.sel; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    nbusy = 0; donej = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) @(negedge clk);
      if (v.extra != 0 && j == v.extra) begin value = 5; ld = 1'b1; end
      if (v.extra != 0 && j == v.extra + 1) ld = 1'b0;
      if (done) begin donej = j; break; end
      if (busy) nbusy++;
    end
    ld = 1'b0;
    check("done_latency", donej, 12);
    check("busy_cycles", nbusy, 11);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    if (donej != 0) begin
      cur = v;
      mvalid = 1'b1;
    end
    chk_disp("scan_at_done");
    extra_done = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) extra_done++;
      chk_disp("scan");
    end
    check("single_done", extra_done, 0);
    $display("conv value=%0d sel=%0d done_at=%0d busy_cycles=%0d", v.val, v.sel, donej, nbusy);
  endtask

  initial begin
    int ndone;
    vecs[0] = mk(10'd37,   2'b01, 0, D7,   D3,   LZ,   UC);
    vecs[1] = mk(10'd999,  2'b10, 0, D9,   D9,   D9,   UK);
    vecs[2] = mk(10'd1000, 2'b10, 0, DASH, DASH, DASH, UK);
    vecs[3] = mk(10'd212,  2'b00, 5, D2,   D1,   D2,   UF);
    vecs[4] = mk(10'd0,    2'b01, 0, D0,   LZ,   LZ,   UC);
    vecs[5] = mk(10'd86,   2'b11, 0, D6,   D8,   LZ,   UK);

    // Reset state while clr is held low.
    #12;
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_disp("blank_before_first_done");
    end
    $display("reset check complete");

    for (int i = 0; i < 6; i++) run_conv(vecs[i]);

    // Commit 37, start 450, check the old digits hold, then abort.
    run_conv(vecs[0]);
    @(negedge clk);
    value = 10'd450; sel = 2'b00; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_in_shift", {31'd0, busy}, 32'd1);
      chk_disp("hold_during_conv");
    end
    #2;
    clr = 1'b0;
    mvalid = 1'b0;
    #1;
    check("abort_an", {28'd0, an}, 32'hF);
    check("abort_seg", {25'd0, seg}, 32'h7F);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
      chk_disp("blank_after_abort");
    end
    check("no_done_after_abort", ndone, 0);
    $display("abort sequence done_pulses=%0d", ndone);

    run_conv(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_display_driver.md
Name: temp_display_driver

Overview:
Downstream stage of the temperature converter. Captures the converter's binary temperature result and unit select on a load strobe, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes four active-low seven-segment digits. Digit 3 shows the unit letter; digits 2..0 show the value.

Parameters:
DATA_W, 10, width of binary temperature input; values 0..999 displayable
REFRESH_DIV, 50000, clk cycles each digit is lit before advancing (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous, active-low reset (0 = reset)
value  input  DATA_W  unsigned binary temperature from converter
sel  input  2  unit select: 00 Fahrenheit, 01 Celsius, 1x Kelvin
ld  input  1  load strobe, sampled on rising clk
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new digits are committed to display
an  output  4  digit anodes, active-low, one-hot when lit
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (clr=0, async): FSM=IDLE, busy=0, done=0, an=4'b1111, seg=7'b1111111, refresh counter=0, digit index=0, display_valid=0.
- FSM states:
  - IDLE: ld=1 captures value and sel into shift/unit registers, clears BCD regs and iteration count, goes to SHIFT.
  - SHIFT: each cycle adds 3 to any BCD nibble >=5, then shifts {bcd,bin} left 1. After exactly DATA_W cycles, goes to COMMIT.
  - COMMIT: one cycle. Loads display regs (hundreds, tens, ones, unit), sets display_valid=1, done=1, and returns to IDLE.
- busy=1 in SHIFT and COMMIT.
- Latency: ld sampled at edge N gives done=1 during the cycle after edge N+DATA_W+1. The display changes from that cycle on.
- ld while busy is ignored, not queued. ld coincident with COMMIT is ignored; ld is accepted again from IDLE on the next cycle.
- Overflow: captured value >999 commits the digits as three dashes (7'b0111111); the unit letter is still shown.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1, then wraps to 0 and advances the digit index 0→1→2→3→0.
  - Refresh runs independently of the FSM and is never stalled.
  - an[idx]=0, all other an bits=1, only when display_valid=1; otherwise an=4'b1111.
- Digit map:
  - idx 0 = ones, 1 = tens, 2 = hundreds, 3 = unit.
  - Unit codes: F=0001110, C=1000110, K shown as H=0001001.
- Decimal codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- seg is registered and aligned with an; no glitch between digits.
- The displayed digits hold their previous value throughout a new conversion.
- Reset mid-conversion aborts immediately; the display returns to blank.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: the hundreds digit is blanked (seg=1111111, anode still driven) when it is 0. The tens digit is blanked when both hundreds and tens are 0. The ones digit is always shown, and dashes are never blanked.
- Undefined: all three value digits are always shown, including leading zeros.

Test Plan:
- Reset check (REFRESH_DIV=4 for all tests): assert clr=0 mid-run → an=1111, seg=1111111, busy=0 asynchronously; no anode goes low until the first done.
- Celsius conversion: value=37, sel=01, ld 1 cycle → busy high for 11 cycles, done pulse 11 cycles after ld edge. Scan shows idx0 seg=1111000 (7), idx1 0110000 (3), idx2 1000000 (0, or blank with LEADING_ZERO_BLANK_EN), idx3 1000110 (C); each anode low 4 cycles in order 1110, 1101, 1011, 0111.
- Kelvin boundary: value=999, sel=10 → digits 9,9,9 (0010000) and unit 0001001. Then value=1000 → three dashes 0111111 with the unit still shown.
- Load while busy: ld at cycle 0 (value=212, sel=00), ld again at cycle 5 (value=5) → second ld ignored; display shows 2,1,2,F; only one done pulse.
- Zero with blanking: value=0, sel=01 with LEADING_ZERO_BLANK_EN → idx2 and idx1 seg=1111111, idx0 1000000. Without the macro, all three show 1000000.
- Abort: clr low during SHIFT of value=450 after an earlier commit of 37 → display blank; after release, no done pulse until a new ld.
